clk_ratio_checker: RTL and testbench

Receive-side monitor for the divided clocks produced by the clock-divider blocks. It samples a divided clock (e.g. divide-by-7) in the `clk` domain and measures its period and high time in `clk` cycles. It compares each period against an expected ratio and reports lock, mismatch and loss-of-clock. It sits beside each divider instance as a built-in self-check and as a lock indicator for downstream logic.

---
 rtl/clk_ratio_checker.sv | 169 ++++++++++++++++
 tb/tb_clk_ratio_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ratio_checker.sv
// Receive-side monitor for a divided clock: measures period and high time in clk cycles,
// checks the period against EXP_PERIOD +/- TOL and reports lock, sticky error and loss-of-clock.
module clk_ratio_checker #(
    parameter int WIDTH      = 8,
    parameter int EXP_PERIOD = 7,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_div_clk,
    input  logic             i_err_clr,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_period_valid,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_timeout
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} stateT;

    localparam logic [WIDTH-1:0] EXP_W  = WIDTH'(EXP_PERIOD);
    localparam logic [WIDTH-1:0] TOL_W  = WIDTH'(TOL);
    localparam logic [WIDTH-1:0] TMO_W  = WIDTH'(TIMEOUT);
    localparam logic [3:0]       LOCK_W = 4'(LOCK_COUNT);

    stateT            state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic [WIDTH-1:0] periodCnt_q, periodCnt_d;
    logic [WIDTH-1:0] highCnt_q, highCnt_d;
    logic [3:0]       matchCnt_q, matchCnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             errSet;
    logic             rise;
    logic [WIDTH-1:0] periodDiff;
    logic             isMatch;
    logic             timeoutHit;

    // Third flop after the two-stage synchronizer gives a clean rising-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= i_div_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise       = sync2_q & ~sync3_q;
    assign periodDiff = (periodCnt_q >= EXP_W) ? (periodCnt_q - EXP_W) : (EXP_W - periodCnt_q);
    assign isMatch    = (periodDiff <= TOL_W) && (highCnt_q != '0) && (highCnt_q < periodCnt_q);
    assign timeoutHit = (periodCnt_q == TMO_W) && !rise;

    always_comb begin
        state_d     = state_q;
        periodCnt_d = periodCnt_q;
        highCnt_d   = highCnt_q;
        matchCnt_d  = matchCnt_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        errSet      = 1'b0;

        if (!i_en) begin
            state_d     = IDLE;
            periodCnt_d = '0;
            highCnt_d   = '0;
            matchCnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    periodCnt_d = '0;
                    highCnt_d   = '0;
                    matchCnt_d  = '0;
                    // The first edge only starts counting; the partial period before it is discarded.
                    if (rise) begin
                        state_d     = MEASURE;
                        periodCnt_d = WIDTH'(1);
                        highCnt_d   = WIDTH'(1);
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        periodCnt_d = WIDTH'(1);
                        highCnt_d   = WIDTH'(1);
                        period_d    = periodCnt_q;
                        high_d      = highCnt_q;
                        valid_d     = 1'b1;
                        if (isMatch) begin
                            if (state_q == MEASURE) begin
                                matchCnt_d = matchCnt_q + 4'd1;
                                if (matchCnt_q + 4'd1 >= LOCK_W) begin
                                    state_d = LOCKED;
                                end
                            end
                        end else begin
                            matchCnt_d = '0;
                            if (state_q == LOCKED) begin
                                errSet  = 1'b1;
                                state_d = MEASURE;
                            end
                        end
                    end else if (timeoutHit) begin
                        timeout_d   = 1'b1;
                        errSet      = 1'b1;
                        state_d     = IDLE;
                        periodCnt_d = '0;
                        highCnt_d   = '0;
                        matchCnt_d  = '0;
                    end else begin
                        // Both counters saturate at TIMEOUT so a stuck clock can never wrap them.
                        if (periodCnt_q < TMO_W) begin
                            periodCnt_d = periodCnt_q + WIDTH'(1);
                        end
                        if (sync2_q && (highCnt_q < TMO_W)) begin
                            highCnt_d = highCnt_q + WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_d = errSet ? 1'b1 : (i_err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            periodCnt_q <= '0;
            highCnt_q   <= '0;
            matchCnt_q  <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            periodCnt_q <= periodCnt_d;
            highCnt_q   <= highCnt_d;
            matchCnt_q  <= matchCnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_period       = period_q;
    assign o_high         = high_q;
    assign o_period_valid = valid_q;
    assign o_locked       = (state_q == LOCKED);
    assign o_err          = err_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_clk_ratio_checker.sv
// Scoreboard bench for clk_ratio_checker: one instance with TOL=0 for lock/mismatch/timeout/reset,
// a second with TOL=1 for the tolerance window.
module tb_clk_ratio_checker;

    typedef struct {
        int period;
        int high;
        bit locked;
        bit err;
    } capT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en1 = 1'b0, divClk1 = 1'b0, errClr1 = 1'b0;
    logic       en2 = 1'b0, divClk2 = 1'b0, errClr2 = 1'b0;
    logic [7:0] period1, high1, period2, high2;
    logic       valid1, locked1, err1, timeout1;
    logic       valid2, locked2, err2, timeout2;

    int  cyc = 0;
    int  compared = 0;
    int  failed = 0;
    capT q1[$];
    capT q2[$];
    int  tq[$];

    clk_ratio_checker #(.WIDTH(8), .EXP_PERIOD(7), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(32)) dut1 (
        .clk(clk), .reset(reset), .i_en(en1), .i_div_clk(divClk1), .i_err_clr(errClr1),
        .o_period(period1), .o_high(high1), .o_period_valid(valid1),
        .o_locked(locked1), .o_err(err1), .o_timeout(timeout1)
    );

    clk_ratio_checker #(.WIDTH(8), .EXP_PERIOD(7), .TOL(1), .LOCK_COUNT(4), .TIMEOUT(32)) dut2 (
        .clk(clk), .reset(reset), .i_en(en2), .i_div_clk(divClk2), .i_err_clr(errClr2),
        .o_period(period2), .o_high(high2), .o_period_valid(valid2),
        .o_locked(locked2), .o_err(err2), .o_timeout(timeout2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectCapture(input int sel, input int p, input int h, input bit l, input bit e);
        capT c;
        c.period = p;
        c.high   = h;
        c.locked = l;
        c.err    = e;
        if (sel == 0) q1.push_back(c);
        else          q2.push_back(c);
    endtask

    // One divided-clock period: hi cycles high then lo cycles low; errClr pulses in cycle clrCycle.
    task automatic applyStimulus(input int sel, input int hi, input int lo, input int clrCycle);
        for (int c = 0; c < hi + lo; c++) begin
            if (sel == 0) begin
                divClk1 = (c < hi);
                errClr1 = (c == clrCycle);
            end else begin
                divClk2 = (c < hi);
                errClr2 = (c == clrCycle);
            end
            @(posedge clk);
            #1;
        end
        errClr1 = 1'b0;
        errClr2 = 1'b0;
    endtask

    task automatic monitorCapture(input int sel, input int p, input int h, input bit l, input bit e);
        capT exp;
        compared++;
        if ((sel == 0 && q1.size() == 0) || (sel == 1 && q2.size() == 0)) begin
            failed++;
            $display("[TB] FAIL dut%0d capture: unexpected valid with period=%0d high=%0d locked=%0d err=%0d",
                     sel + 1, p, h, l, e);
        end else begin
            exp = (sel == 0) ? q1.pop_front() : q2.pop_front();
            if (p != exp.period || h != exp.high || l != exp.locked || e != exp.err) begin
                failed++;
                $display("[TB] FAIL dut%0d capture: got period=%0d high=%0d locked=%0d err=%0d, expected period=%0d high=%0d locked=%0d err=%0d",
                         sel + 1, p, h, l, e, exp.period, exp.high, exp.locked, exp.err);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a capture or a timeout pulse.
    always @(negedge clk) begin
        if (valid1) monitorCapture(0, int'(period1), int'(high1), locked1, err1);
        if (valid2) monitorCapture(1, int'(period2), int'(high2), locked2, err2);
        if (timeout1) begin
            compared++;
            if (tq.size() == 0) begin
                failed++;
                $display("[TB] FAIL dut1 timeout: unexpected pulse at cycle %0d", cyc);
            end else begin
                int expCyc;
                expCyc = tq.pop_front();
                if (cyc != expCyc) begin
                    failed++;
                    $display("[TB] FAIL dut1 timeout: pulse at cycle %0d, expected cycle %0d", cyc, expCyc);
                end
            end
        end
        if (timeout2) begin
            compared++;
            failed++;
            $display("[TB] FAIL dut2 timeout: unexpected pulse at cycle %0d", cyc);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tStart;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset o_period", int'(period1), 0);
        checkOutput("reset o_high", int'(high1), 0);
        checkOutput("reset o_period_valid", int'(valid1), 0);
        checkOutput("reset o_locked", int'(locked1), 0);
        checkOutput("reset o_err", int'(err1), 0);
        checkOutput("reset o_timeout", int'(timeout1), 0);

        $display("[TB] dut1: lock on divide-by-7");
        en1 = 1'b1;
        applyStimulus(0, 4, 3, -1);
        for (int i = 0; i < 3; i++) begin
            expectCapture(0, 7, 4, 0, 0);
            applyStimulus(0, 4, 3, -1);
        end
        expectCapture(0, 7, 4, 1, 0);
        applyStimulus(0, 4, 4, -1);

        $display("[TB] dut1: mismatch after lock, relock, clear");
        expectCapture(0, 8, 4, 0, 1);
        applyStimulus(0, 4, 3, -1);
        for (int i = 0; i < 3; i++) begin
            expectCapture(0, 7, 4, 0, 1);
            applyStimulus(0, 4, 3, -1);
        end
        expectCapture(0, 7, 4, 1, 1);
        applyStimulus(0, 4, 3, 5);
        checkOutput("err cleared", int'(err1), 0);
        checkOutput("locked after clear", int'(locked1), 1);

        $display("[TB] dut1: clear/set collision");
        expectCapture(0, 7, 4, 1, 0);
        applyStimulus(0, 4, 5, -1);
        expectCapture(0, 9, 4, 0, 1);
        applyStimulus(0, 4, 3, 2);
        checkOutput("err after collision", int'(err1), 1);

        $display("[TB] dut1: loss of clock");
        for (int i = 0; i < 3; i++) begin
            expectCapture(0, 7, 4, 0, 1);
            applyStimulus(0, 4, 3, -1);
        end
        expectCapture(0, 7, 4, 1, 1);
        tStart = cyc;
        tq.push_back(tStart + 35);
        applyStimulus(0, 4, 40, 10);
        checkOutput("err after timeout", int'(err1), 1);
        checkOutput("locked after timeout", int'(locked1), 0);
        checkOutput("timeout pulse drained", tq.size(), 0);
        applyStimulus(0, 4, 3, -1);
        for (int i = 0; i < 3; i++) begin
            expectCapture(0, 7, 4, 0, 1);
            applyStimulus(0, 4, 3, -1);
        end
        expectCapture(0, 7, 4, 1, 1);
        applyStimulus(0, 4, 3, -1);

        $display("[TB] dut1: enable drop while locked");
        en1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("en drop o_locked", int'(locked1), 0);
        checkOutput("en drop o_period", int'(period1), 7);
        checkOutput("en drop o_err", int'(err1), 1);
        repeat (2) @(posedge clk);
        #1;
        en1 = 1'b1;
        applyStimulus(0, 4, 3, -1);
        for (int i = 0; i < 3; i++) begin
            expectCapture(0, 7, 4, 0, 1);
            applyStimulus(0, 4, 3, -1);
        end
        expectCapture(0, 7, 4, 1, 1);
        applyStimulus(0, 4, 3, -1);

        $display("[TB] dut1: async reset while locked");
        checkOutput("locked before reset", int'(locked1), 1);
        divClk1 = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async reset o_period", int'(period1), 0);
        checkOutput("async reset o_high", int'(high1), 0);
        checkOutput("async reset o_locked", int'(locked1), 0);
        checkOutput("async reset o_err", int'(err1), 0);
        checkOutput("async reset o_period_valid", int'(valid1), 0);
        en1 = 1'b0;
        divClk1 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] dut2: tolerance window");
        en2 = 1'b1;
        applyStimulus(1, 3, 3, -1);
        expectCapture(1, 6, 3, 0, 0);
        applyStimulus(1, 4, 4, -1);
        expectCapture(1, 8, 4, 0, 0);
        applyStimulus(1, 3, 3, -1);
        expectCapture(1, 6, 3, 0, 0);
        applyStimulus(1, 4, 4, -1);
        expectCapture(1, 8, 4, 1, 0);
        applyStimulus(1, 4, 5, -1);
        expectCapture(1, 9, 4, 0, 1);
        applyStimulus(1, 3, 3, -1);
        checkOutput("dut2 err after period 9", int'(err2), 1);
        en2 = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("dut1 scoreboard drained", q1.size(), 0);
        checkOutput("dut2 scoreboard drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
